// File: rtl/mult_req_sched.sv
// mult_req_sched
// Queues operand pairs in a small FIFO and hands them, one at a time, to an
// external multi-cycle shift-add multiplier. Products are presented on a
// valid/ready output port in the same order the pairs were pushed.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        operand pair handshake (in_a, in_b)
//   mul_start                one-cycle launch pulse to the multiplier
//   mul_a, mul_b             operands, stable from mul_start until mul_done
//   mul_done, mul_result     multiplier completion and product (mod 2^W)
//   out_valid/out_ready      product handshake (out_result)
//   done_cnt                 wrapping count of delivered products
//   err_spurious             sticky: mul_done seen outside WAIT
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no operation in flight; pops the FIFO head when occupancy > 0
// ISSUE | operands loaded, mul_start high for this single cycle
// WAIT  | waiting (unbounded) for mul_done, then captures the product
// HOLD  | out_valid high until the consumer takes out_result
module mult_req_sched #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    output logic         mul_start,
    output logic [W-1:0] mul_a,
    output logic [W-1:0] mul_b,
    input  logic         mul_done,
    input  logic [W-1:0] mul_result,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_result,
    output logic [15:0]  done_cnt,
    output logic         err_spurious
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OW = PW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t         state_q, state_d;

    logic [W-1:0]   fifo_a_q [DEPTH];
    logic [W-1:0]   fifo_b_q [DEPTH];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [OW-1:0]  occ_q, occ_d;

    logic [W-1:0]   mul_a_q, mul_a_d;
    logic [W-1:0]   mul_b_q, mul_b_d;
    logic [W-1:0]   out_result_q, out_result_d;
    logic [15:0]    done_cnt_q, done_cnt_d;
    logic           err_q, err_d;

    logic           push;
    logic           pop;
    logic           capture;
    logic           deliver;

    // in_ready comes only from registered occupancy, so a pop from a full
    // FIFO frees a slot visible one cycle later, never combinationally.
    assign in_ready = (occ_q != OW'(DEPTH));
    assign push     = in_valid && in_ready;

    // FSM next-state and decoded controls. The pop decision also looks only
    // at registered occupancy, so a pair pushed into an empty FIFO is popped
    // on the following edge rather than the same one.
    always_comb begin
        state_d   = state_q;
        pop       = 1'b0;
        capture   = 1'b0;
        deliver   = 1'b0;
        mul_start = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                if (occ_q != '0) begin
                    pop     = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                mul_start = 1'b1;
                state_d   = WAIT;
            end
            WAIT: begin
                if (mul_done) begin
                    capture = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    deliver = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath next-state.
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        occ_d        = occ_q;
        mul_a_d      = mul_a_q;
        mul_b_d      = mul_b_q;
        out_result_d = out_result_q;
        done_cnt_d   = done_cnt_q;
        err_d        = err_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
            mul_a_d  = fifo_a_q[rd_ptr_q];
            mul_b_d  = fifo_b_q[rd_ptr_q];
        end
        case ({push, pop})
            2'b10:   occ_d = occ_q + OW'(1);
            2'b01:   occ_d = occ_q - OW'(1);
            default: occ_d = occ_q;
        endcase

        if (capture) begin
            out_result_d = mul_result;
        end
        if (deliver) begin
            done_cnt_d = done_cnt_q + 16'd1;
        end
        // A completion that arrives outside WAIT carries no data we can trust.
        if (mul_done && (state_q != WAIT)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            occ_q        <= '0;
            mul_a_q      <= '0;
            mul_b_q      <= '0;
            out_result_q <= '0;
            done_cnt_q   <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            occ_q        <= occ_d;
            mul_a_q      <= mul_a_d;
            mul_b_q      <= mul_b_d;
            out_result_q <= out_result_d;
            done_cnt_q   <= done_cnt_d;
            err_q        <= err_d;
        end
    end

    // FIFO storage needs no reset: entries are only read once written.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_a_q[wr_ptr_q] <= in_a;
            fifo_b_q[wr_ptr_q] <= in_b;
        end
    end

    assign mul_a        = mul_a_q;
    assign mul_b        = mul_b_q;
    assign out_result   = out_result_q;
    assign done_cnt     = done_cnt_q;
    assign err_spurious = err_q;

endmodule

// File: tb/tb_mult_req_sched.sv
`timescale 1ns/1ps
// Bench for mult_req_sched: a behavioural multiplier answers mul_start after
// a programmable latency (or stalls), a monitor records delivered products,
// and each test compares them against products queued at push time.
module tb_mult_req_sched;

    localparam int W     = 32;
    localparam int DEPTH = 4;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         mul_start;
    logic [W-1:0] mul_a;
    logic [W-1:0] mul_b;
    logic         mul_done;
    logic [W-1:0] mul_result;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_result;
    logic [15:0]  done_cnt;
    logic         err_spurious;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] sb_q[$];
    logic [W-1:0] rx_q[$];

    int           start_cnt   = 0;
    int           model_lat   = 4;
    bit           model_stall = 1'b0;
    bit           spur_req    = 1'b0;
    bit           model_busy  = 1'b0;
    int           model_cnt   = 0;
    logic [W-1:0] model_a;
    logic [W-1:0] model_b;

    mult_req_sched #(.W(W), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .mul_start    (mul_start),
        .mul_a        (mul_a),
        .mul_b        (mul_b),
        .mul_done     (mul_done),
        .mul_result   (mul_result),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .done_cnt     (done_cnt),
        .err_spurious (err_spurious)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] prod(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] f;
        f = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        return f[W-1:0];
    endfunction

    // Multiplier model: sees mul_start at the falling edge of cycle S and
    // raises mul_done for the cycle S + model_lat (held off while stalled).
    initial begin
        mul_done   = 1'b0;
        mul_result = '0;
        forever begin
            @(negedge clk);
            mul_done = 1'b0;
            if (spur_req) begin
                mul_done   = 1'b1;
                mul_result = 32'hDEAD_BEEF;
                spur_req   = 1'b0;
            end else if (model_busy) begin
                if (model_cnt > 0) model_cnt--;
                if (model_cnt == 0 && !model_stall) begin
                    mul_done   = 1'b1;
                    mul_result = prod(model_a, model_b);
                    model_busy = 1'b0;
                end
            end
            if (mul_start) begin
                start_cnt++;
                model_busy = 1'b1;
                model_cnt  = model_lat;
                model_a    = mul_a;
                model_b    = mul_b;
            end
        end
    end

    // Output monitor: a product accepted at the next rising edge is recorded.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) rx_q.push_back(out_result);
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [W-1:0] a, input logic [W-1:0] b, input int budget, output bit ok);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        ok       = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (in_ready) begin
                tick();
                ok = 1'b1;
                break;
            end
            tick();
        end
        in_valid = 1'b0;
        if (ok) sb_q.push_back(prod(a, b));
    endtask

    task automatic wait_rx(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (rx_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_start(input int prev, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (start_cnt > prev) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (mul_start !== 1'b0) begin failures++; $display("FAIL reset_mul_start: got %b want 0", mul_start); end
        checks++; if (done_cnt !== 16'd0) begin failures++; $display("FAIL reset_done_cnt: got %0d want 0", done_cnt); end
        checks++; if (err_spurious !== 1'b0) begin failures++; $display("FAIL reset_err: got %b want 0", err_spurious); end
        checks++; if (out_result !== '0 || mul_a !== '0 || mul_b !== '0) begin
            failures++; $display("FAIL reset_data: out_result=%h mul_a=%h mul_b=%h want 0", out_result, mul_a, mul_b);
        end
    endtask

    task automatic test_single();
        bit ok;
        int s0;
        int k;
        logic [W-1:0] exp_v;
        model_lat = 32;
        s0 = start_cnt;
        push(32'd3, 32'd5, 10, ok);
        checks++; if (!ok) begin failures++; $display("FAIL single_push: not accepted"); end
        checks++; if (mul_start !== 1'b0) begin failures++; $display("FAIL single_start_early: got %b want 0", mul_start); end
        tick();
        checks++; if (mul_start !== 1'b1 || mul_a !== 32'd3 || mul_b !== 32'd5) begin
            failures++; $display("FAIL single_issue: mul_start=%b mul_a=%0d mul_b=%0d want 1/3/5", mul_start, mul_a, mul_b);
        end
        k = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            k++;
            if (out_valid) break;
        end
        checks++; if (k !== 33) begin failures++; $display("FAIL single_latency: out_valid after %0d cycles want 33", k); end
        checks++; if (out_result !== 32'd15) begin failures++; $display("FAIL single_result: got %0d want 15", out_result); end
        wait_rx(1, 20, ok);
        checks++; if (!ok) begin failures++; $display("FAIL single_rx_timeout: got %0d products want 1", rx_q.size()); end
        else begin
            exp_v = sb_q.pop_front();
            checks++; if (rx_q[0] !== exp_v) begin failures++; $display("FAIL single_rx: got %0d want %0d", rx_q[0], exp_v); end
            void'(rx_q.pop_front());
        end
        checks++; if (done_cnt !== 16'd1) begin failures++; $display("FAIL single_done_cnt: got %0d want 1", done_cnt); end
        checks++; if (start_cnt - s0 !== 1) begin failures++; $display("FAIL single_start_count: got %0d want 1", start_cnt - s0); end
        checks++; if (out_valid !== 1'b0 || out_result !== 32'd15) begin
            failures++; $display("FAIL single_hold_after: out_valid=%b out_result=%0d want 0/15", out_valid, out_result);
        end
    endtask

    task automatic test_truncate();
        bit ok;
        logic [W-1:0] exp_v;
        model_lat = 5;
        push(32'hFFFF_FFFF, 32'd2, 10, ok);
        checks++; if (!ok) begin failures++; $display("FAIL trunc_push: not accepted"); end
        wait_rx(1, 50, ok);
        checks++; if (!ok) begin failures++; $display("FAIL trunc_rx_timeout: got %0d products want 1", rx_q.size()); end
        else begin
            exp_v = sb_q.pop_front();
            checks++; if (rx_q[0] !== exp_v || rx_q[0] !== 32'hFFFF_FFFE) begin
                failures++; $display("FAIL trunc_result: got %h want %h", rx_q[0], exp_v);
            end
            void'(rx_q.pop_front());
        end
        checks++; if (done_cnt !== 16'd2) begin failures++; $display("FAIL trunc_done_cnt: got %0d want 2", done_cnt); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        bit popped;
        bit early;
        int s0;
        int n;
        logic [W-1:0] exp_v;
        model_lat   = 3;
        model_stall = 1'b1;
        s0 = start_cnt;
        push(32'd7, 32'd11, 10, ok);
        checks++; if (!ok) begin failures++; $display("FAIL b2b_blocker_push: not accepted"); end
        wait_start(s0, 20, ok);
        checks++; if (!ok) begin failures++; $display("FAIL b2b_blocker_start: no mul_start"); end
        for (int i = 0; i < 4; i++) begin
            push(32'(i + 2), 32'(100 + i), 1, ok);
            checks++; if (!ok) begin failures++; $display("FAIL b2b_push%0d: not accepted back-to-back", i); end
        end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL b2b_full: in_ready got %b want 0", in_ready); end
        in_valid    = 1'b1;
        in_a        = 32'd6;
        in_b        = 32'd104;
        model_stall = 1'b0;
        popped = 1'b0;
        early  = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (mul_start) begin
                popped = 1'b1;
                break;
            end
            if (in_ready) early = 1'b1;
        end
        checks++; if (!popped) begin failures++; $display("FAIL b2b_pop_timeout: first pop not seen"); end
        checks++; if (early) begin failures++; $display("FAIL b2b_ready_early: in_ready rose before the pop took effect"); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_after_pop: got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        sb_q.push_back(prod(32'd6, 32'd104));
        n = sb_q.size();
        wait_rx(n, 200, ok);
        checks++; if (!ok) begin failures++; $display("FAIL b2b_rx_timeout: got %0d products want %0d", rx_q.size(), n); end
        for (int i = 0; i < n; i++) begin
            exp_v = sb_q.pop_front();
            if (rx_q.size() > 0) begin
                checks++; if (rx_q[0] !== exp_v) begin failures++; $display("FAIL b2b_order%0d: got %0d want %0d", i, rx_q[0], exp_v); end
                void'(rx_q.pop_front());
            end
        end
        checks++; if (done_cnt !== 16'd8) begin failures++; $display("FAIL b2b_done_cnt: got %0d want 8", done_cnt); end
    endtask

    task automatic test_hold();
        bit ok;
        bit seen;
        int s0;
        int bad;
        logic [W-1:0] r;
        logic [W-1:0] exp_v;
        model_lat = 4;
        out_ready = 1'b0;
        push(32'd9, 32'd9, 10, ok);
        push(32'd12, 32'd3, 10, ok);
        push(32'd1000, 32'd1000, 10, ok);
        checks++; if (sb_q.size() !== 3) begin failures++; $display("FAIL hold_push: queued %0d want 3", sb_q.size()); end
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        checks++; if (!seen) begin failures++; $display("FAIL hold_timeout: out_valid never rose"); end
        r  = out_result;
        s0 = start_cnt;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_valid !== 1'b1 || out_result !== r) bad++;
        end
        checks++; if (bad !== 0) begin failures++; $display("FAIL hold_stable: %0d unstable cycles want 0", bad); end
        checks++; if (start_cnt !== s0) begin failures++; $display("FAIL hold_no_start: %0d extra starts want 0", start_cnt - s0); end
        checks++; if (rx_q.size() !== 0) begin failures++; $display("FAIL hold_no_delivery: %0d delivered want 0", rx_q.size()); end
        out_ready = 1'b1;
        wait_rx(3, 100, ok);
        checks++; if (!ok) begin failures++; $display("FAIL hold_rx_timeout: got %0d products want 3", rx_q.size()); end
        for (int i = 0; i < 3; i++) begin
            exp_v = sb_q.pop_front();
            if (rx_q.size() > 0) begin
                checks++; if (rx_q[0] !== exp_v) begin failures++; $display("FAIL hold_order%0d: got %0d want %0d", i, rx_q[0], exp_v); end
                void'(rx_q.pop_front());
            end
        end
        checks++; if (done_cnt !== 16'd11) begin failures++; $display("FAIL hold_done_cnt: got %0d want 11", done_cnt); end
    endtask

    task automatic test_spurious();
        int s0;
        int bad;
        logic [15:0] d0;
        tick();
        tick();
        d0 = done_cnt;
        s0 = start_cnt;
        checks++; if (err_spurious !== 1'b0) begin failures++; $display("FAIL spur_pre: err got %b want 0", err_spurious); end
        spur_req = 1'b1;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid !== 1'b0) bad++;
        end
        checks++; if (err_spurious !== 1'b1) begin failures++; $display("FAIL spur_err: got %b want 1", err_spurious); end
        checks++; if (bad !== 0) begin failures++; $display("FAIL spur_out_valid: %0d cycles valid want 0", bad); end
        checks++; if (done_cnt !== d0) begin failures++; $display("FAIL spur_done_cnt: got %0d want %0d", done_cnt, d0); end
        checks++; if (start_cnt !== s0 || rx_q.size() !== 0) begin
            failures++; $display("FAIL spur_activity: starts=%0d products=%0d want 0/0", start_cnt - s0, rx_q.size());
        end
        tick();
        tick();
        checks++; if (err_spurious !== 1'b1) begin failures++; $display("FAIL spur_sticky: got %b want 1", err_spurious); end
    endtask

    task automatic test_reset_in_wait();
        bit ok;
        int s0;
        logic [W-1:0] exp_v;
        model_lat   = 4;
        model_stall = 1'b1;
        s0 = start_cnt;
        push(32'd2, 32'd3, 10, ok);
        push(32'd4, 32'd5, 10, ok);
        push(32'd6, 32'd8, 10, ok);
        wait_start(s0, 20, ok);
        checks++; if (!ok) begin failures++; $display("FAIL rstw_start: no mul_start"); end
        tick();
        tick();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++; $display("FAIL rstw_pre: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb_q.delete();
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || mul_start !== 1'b0) begin
            failures++; $display("FAIL rstw_ctrl: in_ready=%b out_valid=%b mul_start=%b want 1/0/0", in_ready, out_valid, mul_start);
        end
        checks++; if (done_cnt !== 16'd0 || err_spurious !== 1'b0) begin
            failures++; $display("FAIL rstw_cnt_err: done_cnt=%0d err=%b want 0/0", done_cnt, err_spurious);
        end
        checks++; if (mul_a !== '0 || mul_b !== '0 || out_result !== '0) begin
            failures++; $display("FAIL rstw_data: mul_a=%h mul_b=%h out_result=%h want 0", mul_a, mul_b, out_result);
        end
        s0 = start_cnt;
        for (int i = 0; i < 5; i++) tick();
        checks++; if (start_cnt !== s0) begin failures++; $display("FAIL rstw_fifo_empty: %0d starts after reset want 0", start_cnt - s0); end
        model_stall = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        checks++; if (err_spurious !== 1'b1 || out_valid !== 1'b0) begin
            failures++; $display("FAIL rstw_late_done: err=%b out_valid=%b want 1/0", err_spurious, out_valid);
        end
        push(32'd6, 32'd7, 10, ok);
        wait_rx(1, 50, ok);
        checks++; if (!ok) begin failures++; $display("FAIL rstw_rx_timeout: got %0d products want 1", rx_q.size()); end
        else begin
            exp_v = sb_q.pop_front();
            checks++; if (rx_q[0] !== exp_v) begin failures++; $display("FAIL rstw_result: got %0d want %0d", rx_q[0], exp_v); end
            void'(rx_q.pop_front());
        end
        checks++; if (done_cnt !== 16'd1 || start_cnt - s0 !== 1) begin
            failures++; $display("FAIL rstw_after: done_cnt=%0d starts=%0d want 1/1", done_cnt, start_cnt - s0);
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b1;
        test_reset();
        test_single();
        test_truncate();
        test_back_to_back();
        test_hold();
        test_spurious();
        test_reset_in_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mult_req_sched.md
MULT_REQ_SCHED -- requirements
Module: mult_req_sched

Interface
REQ-001: The module SHALL have parameter W, default 32, giving the operand and result width in bits.
REQ-002: The module SHALL have parameter DEPTH, default 4, giving the number of operand FIFO entries (power of two, at least 2).
REQ-003: The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004: The module SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005: The module SHALL have port in_valid, input, 1 bit: an operand pair is offered.
REQ-006: The module SHALL have port in_ready, output, 1 bit: the FIFO can accept a pair.
REQ-007: The module SHALL have ports in_a and in_b, input, W bits each: the multiplicand and the multiplier.
REQ-008: The module SHALL have port mul_start, output, 1 bit: a one-cycle pulse launching the downstream shift-add multiplier.
REQ-009: The module SHALL have ports mul_a and mul_b, output, W bits each: the operands, held stable from mul_start until mul_done.
REQ-010: The module SHALL have port mul_done, input, 1 bit: the multiplier result is valid this cycle.
REQ-011: The module SHALL have port mul_result, input, W bits: the product modulo 2^W.
REQ-012: The module SHALL have port out_valid, output, 1 bit: out_result holds a completed product.
REQ-013: The module SHALL have port out_ready, input, 1 bit: the consumer accepts out_result.
REQ-014: The module SHALL have port out_result, output, W bits: the completed product.
REQ-015: The module SHALL have port done_cnt, output, 16 bits: the count of products delivered.
REQ-016: The module SHALL have port err_spurious, output, 1 bit: sticky flag for mul_done received while not in WAIT.

Function
REQ-017: A push SHALL occur on a rising edge when in_valid and in_ready are both 1; the pair is written at the write pointer.
REQ-018: in_ready SHALL equal (occupancy != DEPTH), combinational from registered occupancy.
REQ-019: The FIFO SHALL be first-in first-out; pointers SHALL wrap from DEPTH-1 to 0.
REQ-020: The FSM SHALL have exactly four states: IDLE, ISSUE, WAIT and HOLD.
REQ-021: IDLE: if occupancy > 0, the FSM SHALL pop the head pair into the mul_a/mul_b registers and go to ISSUE; otherwise it SHALL stay in IDLE.
REQ-022: ISSUE: mul_start SHALL be 1 for exactly this one cycle, then the FSM SHALL go to WAIT.
REQ-023: WAIT: on mul_done=1, the FSM SHALL capture mul_result into out_result and go to HOLD; there SHALL be no timeout.
REQ-024: HOLD: out_valid SHALL be 1; on out_ready=1, done_cnt SHALL increment (wrapping 0xFFFF to 0) and the FSM SHALL go to IDLE.
REQ-025: The minimum turnaround SHALL be: pair pushed at edge N, mul_start high in cycle N+2.
REQ-026: A push and a pop on the same edge SHALL leave occupancy unchanged, and both SHALL take effect.
REQ-027: When the FIFO is full and a pop occurs, in_ready SHALL rise in the following cycle, never the same cycle.
REQ-028: A push into an empty FIFO SHALL NOT be popped on the same edge; the pop occurs on the next edge.
REQ-029: mul_done outside WAIT SHALL be ignored for data and SHALL set err_spurious, which stays 1 until reset.
REQ-030: out_result SHALL hold its value after the handshake until the next capture.
REQ-031: Products SHALL be delivered in push order; no pair is dropped or duplicated.

Reset
REQ-032: When rst=1 at an edge, the module SHALL clear the FSM to IDLE, occupancy to 0, both pointers to 0, mul_a, mul_b and out_result to 0, mul_start=0, out_valid=0, done_cnt=0 and err_spurious=0.
REQ-033: Reset asserted during WAIT or HOLD SHALL abandon the operation with no output; a late mul_done after reset SHALL set err_spurious.
REQ-034: in_ready SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-035: The bench SHALL push a=3, b=5 with the multiplier model answering 32 cycles after mul_start -> exactly one mul_start pulse with mul_a=3, mul_b=5; out_valid with out_result=15; done_cnt=1 after the handshake.
REQ-036: The bench SHALL push 5 pairs back-to-back with the multiplier stalled -> in_ready=0 after 4 pushes, the 5th push accepted one cycle after the first pop, and products returned in push order.
REQ-037: The bench SHALL push a=0xFFFFFFFF, b=2 -> out_result=0xFFFFFFFE, with the product truncated to W bits.
REQ-038: The bench SHALL hold out_ready=0 for 10 cycles in HOLD -> out_valid and out_result stable, no new mul_start, and queued pairs retained.
REQ-039: The bench SHALL pulse mul_done while in IDLE -> err_spurious=1, no out_valid, and done_cnt unchanged.
REQ-040: The bench SHALL assert rst during WAIT with 2 pairs queued -> all outputs at reset values next cycle, occupancy 0, and a subsequent push processed normally.
